sysu_bcd_scan_display: RTL and testbench



---
 rtl/sysu_bcd_scan_display.sv | 100 ++++++++++
 tb/tb_sysu_bcd_scan_display.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/sysu_bcd_scan_display.sv
// Four-digit scanned common-anode 7-segment driver fed by BCD decade counters.
// Define SYSU_SCAN_LZB_EN to enable leading-zero blanking of digits 3..1.
module sysu_bcd_scan_display #(
    parameter int DIV = 50000
) (
    input  logic        CP,
    input  logic        R,
    input  logic [15:0] BCD,
    input  logic        LE,
    input  logic [3:0]  DP_IN,
    output logic [3:0]  AN,
    output logic [6:0]  SEG,
    output logic        DP,
    output logic        TICK
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    logic [1:0]    idx_next;
    logic [15:0]   shadow_bcd;
    logic [3:0]    shadow_dp;
    logic [3:0]    digit;
    logic          tick;
    logic          blank;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return 7'h06;
        endcase
    endfunction

    assign tick     = (cnt == CW'(DIV - 1));
    assign idx_next = idx + 2'd1;
    // The slot being loaded is the one after the advance, read from the pre-capture shadow.
    assign digit    = shadow_bcd[{idx_next, 2'b00} +: 4];

`ifdef SYSU_SCAN_LZB_EN
    // NOTE: every signal written in always_comb gets a default first, or a latch is inferred.
    always_comb begin
        blank = 1'b0;
        case (idx_next)
            2'd1:    blank = (shadow_bcd[15:4]  == 12'h000);
            2'd2:    blank = (shadow_bcd[15:8]  == 8'h00);
            2'd3:    blank = (shadow_bcd[15:12] == 4'h0);
            default: blank = 1'b0;
        endcase
    end
`else
    assign blank = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge CP) begin
        if (R) begin
            cnt        <= '0;
            idx        <= 2'd0;
            // NOTE: the shadow register is reset so a dark display never shows stale digits.
            shadow_bcd <= 16'h0000;
            shadow_dp  <= 4'h0;
            AN         <= 4'hF;
            SEG        <= 7'h7F;
            DP         <= 1'b1;
            TICK       <= 1'b0;
        end else begin
            if (LE) begin
                shadow_bcd <= BCD;
                shadow_dp  <= DP_IN;
            end

            cnt  <= tick ? '0 : cnt + CW'(1);
            TICK <= tick;

            if (tick) begin
                idx <= idx_next;
                if (blank) begin
                    AN  <= 4'hF;
                    SEG <= 7'h7F;
                    DP  <= 1'b1;
                end else begin
                    AN  <= ~(4'b0001 << idx_next);
                    SEG <= seg_decode(digit);
                    DP  <= ~shadow_dp[idx_next];
                end
            end
        end
    end

endmodule

// File: tb/tb_sysu_bcd_scan_display.sv
// Scoreboard bench for sysu_bcd_scan_display: a cycle-accurate reference model
// predicts each output change, a negedge monitor compares every cycle.
module tb_sysu_bcd_scan_display;

    localparam int DIV = 4;

    logic        CP = 1'b0;
    logic        R = 1'b0;
    logic        LE = 1'b0;
    logic [15:0] BCD = 16'h0000;
    logic [3:0]  DP_IN = 4'h0;
    logic [3:0]  AN;
    logic [6:0]  SEG;
    logic        DP;
    logic        TICK;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        int         stamp;
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       tick;
    } exp_t;

    exp_t sb[$];

    // Reference model state: edge index of the last reset edge and the captured digits.
    bit          seen_reset = 1'b0;
    int          rel = 0;
    logic [15:0] m_bcd = 16'h0000;
    logic [3:0]  m_dp = 4'h0;
    logic [6:0]  seg_lut [0:15] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                    7'h00, 7'h10, 7'h06, 7'h06, 7'h06, 7'h06, 7'h06, 7'h06};

    sysu_bcd_scan_display #(.DIV(DIV)) dut (
        .CP   (CP),
        .R    (R),
        .BCD  (BCD),
        .LE   (LE),
        .DP_IN(DP_IN),
        .AN   (AN),
        .SEG  (SEG),
        .DP   (DP),
        .TICK (TICK)
    );

    always #5 CP = ~CP;
    always @(posedge CP) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Predict what the DUT presents after edge e given the inputs sampled at e.
    task automatic model(input int e, input logic r, input logic le,
                         input logic [15:0] bcd, input logic [3:0] dpin);
        exp_t x;
        int   n;
        int   k;
        bit   lzb;
        bit   blanked;
`ifdef SYSU_SCAN_LZB_EN
        lzb = 1'b1;
`else
        lzb = 1'b0;
`endif
        if (r) begin
            seen_reset = 1'b1;
            rel   = e;
            m_bcd = 16'h0000;
            m_dp  = 4'h0;
            x = '{e, 4'hF, 7'h7F, 1'b1, 1'b0};
            sb.push_back(x);
        end else if (seen_reset) begin
            n = e - rel;
            if (n % DIV == 0) begin
                k = (n / DIV) % 4;
                blanked = lzb && (k >= 1) && ((int'(m_bcd) >> (4 * k)) == 0);
                if (blanked) begin
                    x = '{e, 4'hF, 7'h7F, 1'b1, 1'b1};
                end else begin
                    x.stamp = e;
                    x.an    = 4'(15 - (1 << k));
                    x.seg   = seg_lut[(int'(m_bcd) >> (4 * k)) % 16];
                    x.dp    = !m_dp[k];
                    x.tick  = 1'b1;
                end
                sb.push_back(x);
            end
            if (le) begin
                m_bcd = bcd;
                m_dp  = dpin;
            end
        end
    endtask

    // Each step starts at a negedge, targets edge cyc+1, and ends at the following negedge.
    task automatic step(input logic r, input logic le, input logic [15:0] bcd, input logic [3:0] dpin);
        R = r;
        LE = le;
        BCD = bcd;
        DP_IN = dpin;
        model(cyc + 1, r, le, bcd, dpin);
        @(negedge CP);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'($urandom), 4'($urandom));
    endtask

    function automatic logic [15:0] rand_bcd();
        logic [15:0] v;
        for (int d = 0; d < 4; d++)
            v[d*4 +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
        return v;
    endfunction

    // Monitor: pop predictions stamped for the edge just passed; otherwise outputs must hold.
    exp_t cur;
    bit   armed = 1'b0;
    initial begin
        forever begin
            logic exp_tick;
            @(negedge CP);
            exp_tick = 1'b0;
            while (sb.size() > 0 && sb[0].stamp <= cyc) begin
                cur = sb.pop_front();
                armed = 1'b1;
                exp_tick = cur.tick;
            end
            if (armed) begin
                check("AN",   32'(AN),   32'(cur.an));
                check("SEG",  32'(SEG),  32'(cur.seg));
                check("DP",   32'(DP),   32'(cur.dp));
                check("TICK", 32'(TICK), 32'(exp_tick));
            end
        end
    end

    initial begin
        @(negedge CP);
        // Reset held for three cycles, then a dark period until the first tick.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 16'h0000, 4'h0);
        idle(10);

        // Count display 1234 with DP on digit 1.
        step(1'b0, 1'b1, 16'h1234, 4'b0010);
        idle(16);

        // Invalid codes on digits 0 and 1.
        step(1'b0, 1'b1, 16'h09AF, 4'h0);
        idle(16);

        // LE collides with a tick edge while the shadow holds zero.
        step(1'b0, 1'b1, 16'h0000, 4'h0);
        while (((cyc + 1 - rel) % DIV) != 0) idle(1);
        step(1'b0, 1'b1, 16'h5555, 4'h0);
        idle(8);

        // Leading zeros.
        step(1'b0, 1'b1, 16'h0007, 4'hF);
        idle(16);

        // Mid-slot reset at offset 2 of the digit-2 slot.
        while (!((((cyc + 1 - rel) / DIV) % 4 == 2) && ((cyc + 1 - rel) % DIV == 2))) idle(1);
        step(1'b1, 1'b1, 16'h9999, 4'hF);
        idle(12);

        // LE held high: the shadow tracks BCD every cycle.
        for (int i = 0; i < 40; i++) step(1'b0, 1'b1, rand_bcd(), 4'($urandom));

        // Random mix of latches, resets and idle cycles.
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 99) == 0, $urandom_range(0, 7) == 0, rand_bcd(), 4'($urandom));
        idle(8);

        #1;
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
